// File: rtl/uart_mmio_fifo_pkg.sv
// Shared register map, STATUS/CTRL bit positions and address decode helper
// for the memory-mapped UART FIFO block.
package uart_mmio_fifo_pkg;

  localparam logic [31:0] OFF_STATUS = 32'h0;
  localparam logic [31:0] OFF_RXDATA = 32'h4;
  localparam logic [31:0] OFF_TXDATA = 32'h8;
  localparam logic [31:0] OFF_CTRL   = 32'hC;

  localparam int ST_TX_NOT_FULL  = 0;
  localparam int ST_RX_NOT_EMPTY = 1;
  localparam int ST_TX_OVERFLOW  = 2;
  localparam int ST_RX_UNDERFLOW = 3;
  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_TX_COUNT_LSB = 16;
  localparam int ST_COUNT_W      = 8;

  localparam int CTRL_CLEAR = 0;
  localparam int CTRL_FLUSH = 1;

  typedef struct packed {
    logic status;
    logic rxdata;
    logic txdata;
    logic ctrl;
  } reg_hit_t;

  // Exact word match only; unaligned or out-of-window addresses hit nothing.
  function automatic reg_hit_t decode_addr(input logic [31:0] addr,
                                           input logic [31:0] base);
    reg_hit_t hit;
    hit.status = (addr == base + OFF_STATUS);
    hit.rxdata = (addr == base + OFF_RXDATA);
    hit.txdata = (addr == base + OFF_TXDATA);
    hit.ctrl   = (addr == base + OFF_CTRL);
    return hit;
  endfunction

endpackage

// File: rtl/uart_mmio_fifo_fifo.sv
// Synchronous FIFO with occupancy count and flush; head is read combinationally.
module sync_fifo
  import uart_mmio_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full/empty are judged on the state at cycle start, so a push into a
  // full FIFO is dropped even if a pop happens in the same cycle.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_mmio_fifo.sv
// CPU-facing register window around a TX and an RX FIFO feeding a UART
// character interface; loads return registered data one cycle later.
module uart_mmio_fifo
  import uart_mmio_fifo_pkg::*;
#(
  parameter int          DEPTH      = 8,
  parameter int          DATA_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [31:0]           Addr,
  input  logic [31:0]           WData,
  input  logic [3:0]            WE,
  input  logic                  RE,
  output logic [31:0]           RData,
  output logic [DATA_WIDTH-1:0] DataIn,
  output logic                  DataInValid,
  input  logic                  DataInReady,
  input  logic [DATA_WIDTH-1:0] DataOut,
  input  logic                  DataOutValid,
  output logic                  DataOutReady
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  reg_hit_t              hit_p0;
  logic                  wr_p0;
  logic                  tx_push_p0;
  logic                  tx_pop_p0;
  logic                  rx_push_p0;
  logic                  rx_pop_p0;
  logic                  flush_p0;
  logic                  clear_p0;
  logic                  set_ovf_p0;
  logic                  set_unf_p0;
  logic [31:0]           status_p0;
  logic [31:0]           load_p0;
  logic [31:0]           rdata_p1;

  logic                  tx_full;
  logic                  tx_empty;
  logic [CNT_W-1:0]      tx_count;
  logic                  rx_full;
  logic                  rx_empty;
  logic [CNT_W-1:0]      rx_count;
  logic [DATA_WIDTH-1:0] rx_head;
  logic                  tx_overflow;
  logic                  rx_underflow;
  logic                  unused_wdata;

  function automatic logic [31:0] pack_status(input logic             txf,
                                              input logic             rxe,
                                              input logic             ovf,
                                              input logic             unf,
                                              input logic [CNT_W-1:0] rxc,
                                              input logic [CNT_W-1:0] txc);
    logic [31:0] s;
    s                                   = '0;
    s[ST_TX_NOT_FULL]                   = !txf;
    s[ST_RX_NOT_EMPTY]                  = !rxe;
    s[ST_TX_OVERFLOW]                   = ovf;
    s[ST_RX_UNDERFLOW]                  = unf;
    s[ST_RX_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(rxc);
    s[ST_TX_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(txc);
    return s;
  endfunction

  // Stage p0: decode the bus access and derive FIFO strobes from cycle-start state
  assign hit_p0     = decode_addr(Addr, BASE_ADDR);
  assign wr_p0      = |WE;
  assign tx_push_p0 = wr_p0 && hit_p0.txdata;
  assign tx_pop_p0  = DataInValid && DataInReady;
  assign rx_push_p0 = DataOutValid && DataOutReady;
  assign rx_pop_p0  = RE && hit_p0.rxdata;
  assign flush_p0   = wr_p0 && hit_p0.ctrl && WData[CTRL_FLUSH];
  assign clear_p0   = wr_p0 && hit_p0.ctrl && WData[CTRL_CLEAR];
  assign set_ovf_p0 = tx_push_p0 && tx_full;
  assign set_unf_p0 = rx_pop_p0 && rx_empty;

  assign DataInValid  = !tx_empty;
  assign DataOutReady = !rx_full;
  assign unused_wdata = ^WData;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_WIDTH)) u_tx_fifo (
    .clk   (Clock),
    .rst   (Reset),
    .push  (tx_push_p0),
    .pop   (tx_pop_p0),
    .flush (flush_p0),
    .wdata (WData[DATA_WIDTH-1:0]),
    .rdata (DataIn),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_WIDTH)) u_rx_fifo (
    .clk   (Clock),
    .rst   (Reset),
    .push  (rx_push_p0),
    .pop   (rx_pop_p0),
    .flush (flush_p0),
    .wdata (DataOut),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign status_p0 = pack_status(tx_full, rx_empty, tx_overflow, rx_underflow,
                                 rx_count, tx_count);

  always_comb begin
    load_p0 = '0;
    if (hit_p0.status) begin
      load_p0 = status_p0;
    end else if (hit_p0.rxdata && !rx_empty) begin
      load_p0 = 32'(rx_head);
    end
  end

  // Stage p1: registered load data and sticky flags; a set beats a clear
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      if (set_ovf_p0)    tx_overflow <= 1'b1;
      else if (clear_p0) tx_overflow <= 1'b0;
      if (set_unf_p0)    rx_underflow <= 1'b1;
      else if (clear_p0) rx_underflow <= 1'b0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rdata_p1 <= '0;
    end else if (RE) begin
      rdata_p1 <= load_p0;
    end
  end

  assign RData = rdata_p1;

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Randomized scoreboard bench: a queue-based model predicts loads and UART
// handshakes; a negedge monitor pops expectations as the DUT presents them.
module tb_uart_mmio_fifo;

  localparam int          DEPTH = 8;
  localparam int          DW    = 8;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] A_ST  = BASE;
  localparam logic [31:0] A_RX  = BASE + 32'h4;
  localparam logic [31:0] A_TX  = BASE + 32'h8;
  localparam logic [31:0] A_CT  = BASE + 32'hC;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [31:0]   Addr;
  logic [31:0]   WData;
  logic [3:0]    WE;
  logic          RE;
  logic [31:0]   RData;
  logic [DW-1:0] DataIn;
  logic          DataInValid;
  logic          DataInReady;
  logic [DW-1:0] DataOut;
  logic          DataOutValid;
  logic          DataOutReady;

  always #5 Clock = ~Clock;

  uart_mmio_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .BASE_ADDR(BASE)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Addr         (Addr),
    .WData        (WData),
    .WE           (WE),
    .RE           (RE),
    .RData        (RData),
    .DataIn       (DataIn),
    .DataInValid  (DataInValid),
    .DataInReady  (DataInReady),
    .DataOut      (DataOut),
    .DataOutValid (DataOutValid),
    .DataOutReady (DataOutReady)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] m_tx[$];
  logic [DW-1:0] m_rx[$];
  bit            m_ovf = 0;
  bit            m_unf = 0;
  logic [31:0]   exp_rd[$];
  logic [DW-1:0] exp_tx[$];
  logic          exp_dor = 1'b1;
  logic          exp_div = 1'b0;
  bit            mon_en = 0;
  bit            rd_pending = 0;
  logic [31:0]   last_rd = '0;
  logic [31:0]   mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = (m_tx.size() < DEPTH);
    s[1]     = (m_rx.size() != 0);
    s[2]     = m_ovf;
    s[3]     = m_unf;
    s[15:8]  = 8'(m_rx.size());
    s[23:16] = 8'(m_tx.size());
    return s;
  endfunction

  // Drive one cycle of inputs and advance the model by the same cycle.
  task automatic step(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                      input logic re, input logic dir, input logic dov, input logic [DW-1:0] dout);
    bit          tx_full, rx_full, set_o, set_u;
    logic [31:0] st, rd;
    Addr = a; WE = we; WData = wd; RE = re;
    DataInReady = dir; DataOutValid = dov; DataOut = dout;
    tx_full = (m_tx.size() == DEPTH);
    rx_full = (m_rx.size() == DEPTH);
    st      = model_status();
    set_o   = 0;
    set_u   = 0;
    exp_dor = !rx_full;
    exp_div = (m_tx.size() != 0);
    if (re) begin
      rd = '0;
      if (a == A_ST) rd = st;
      else if (a == A_RX) begin
        if (m_rx.size() != 0) rd[DW-1:0] = m_rx.pop_front();
        else set_u = 1;
      end
      exp_rd.push_back(rd);
    end
    if (dir && m_tx.size() != 0) exp_tx.push_back(m_tx.pop_front());
    if (we != 0 && a == A_TX) begin
      if (tx_full) set_o = 1;
      else m_tx.push_back(wd[DW-1:0]);
    end
    if (dov && !rx_full) m_rx.push_back(dout);
    if (we != 0 && a == A_CT) begin
      if (wd[0]) begin m_ovf = 0; m_unf = 0; end
      if (wd[1]) begin m_tx.delete(); m_rx.delete(); end
    end
    m_ovf = m_ovf | set_o;
    m_unf = m_unf | set_u;
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(input logic dir);
    step(32'h0, 4'h0, 32'h0, 1'b0, dir, 1'b0, '0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(a, 4'hF, d, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic rd(input logic [31:0] a);
    step(a, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  always @(negedge Clock) begin
    if (mon_en && !Reset) begin
      if (rd_pending) begin
        if (exp_rd.size() == 0) begin
          checks++; failures++;
          $display("FAIL rdata_unexpected actual=%h expected=none", RData);
        end else begin
          mon_e = exp_rd.pop_front();
          chk("rdata", RData, mon_e);
          last_rd = mon_e;
        end
      end else begin
        chk("rdata_hold", RData, last_rd);
      end
      rd_pending = RE;
      chk("out_ready", 32'(DataOutReady), 32'(exp_dor));
      chk("in_valid", 32'(DataInValid), 32'(exp_div));
      if (DataInValid && DataInReady) begin
        if (exp_tx.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_unexpected actual=%h expected=none", DataIn);
        end else begin
          chk("tx_char", 32'(DataIn), 32'(exp_tx.pop_front()));
        end
      end else if (exp_tx.size() != 0) begin
        checks++; failures++;
        $display("FAIL tx_missing actual=none expected=%h", exp_tx[0]);
        exp_tx.delete();
      end
    end
  end

  initial begin
    Reset = 1'b1;
    Addr = '0; WData = '0; WE = '0; RE = 1'b0;
    DataInReady = 1'b0; DataOutValid = 1'b0; DataOut = '0;
    repeat (2) @(posedge Clock);
    #1;
    chk("reset_rdata", RData, 32'h0);
    chk("reset_in_valid", 32'(DataInValid), 32'h0);
    chk("reset_out_ready", 32'(DataOutReady), 32'h1);
    Reset = 1'b0;
    mon_en = 1;

    // Three TX writes held back, then drained in order.
    wr(A_TX, 32'h41); wr(A_TX, 32'h42); wr(A_TX, 32'h43);
    rd(A_ST);
    chk("tx3_status", RData, 32'h0003_0001);
    chk("tx3_head", 32'(DataIn), 32'h41);
    repeat (4) idle(1'b1);

    // Overflow on the ninth write, then clear.
    for (int i = 0; i < 9; i++) wr(A_TX, 32'h60 + i);
    rd(A_ST);
    chk("tx_ovf_status", RData, 32'h0008_0004);
    wr(A_CT, 32'h1);
    rd(A_ST);
    chk("tx_ovf_cleared", RData, 32'h0008_0000);
    wr(A_CT, 32'h2);
    rd(A_ST);
    chk("flush_status", RData, 32'h0000_0001);

    // RX single character, then underflow.
    step(32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 8'hAA);
    rd(A_RX);
    chk("rx_aa", RData, 32'h0000_00AA);
    rd(A_RX);
    chk("rx_empty_read", RData, 32'h0);
    rd(A_ST);
    chk("rx_unf_status", RData, 32'h0000_0009);
    wr(A_CT, 32'h1);

    // RX fill to full, one read frees a slot.
    for (int i = 0; i < 8; i++) step(32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 8'(8'h10 + i));
    chk("rx_full_ready", 32'(DataOutReady), 32'h0);
    rd(A_RX);
    chk("rx_full_read", RData, 32'h0000_0010);
    chk("rx_after_read_ready", 32'(DataOutReady), 32'h1);
    rd(A_ST);
    chk("rx7_status", RData, 32'h0000_0703);
    wr(A_CT, 32'h2);

    // Concurrent TX push/pop, then flush beating concurrent traffic.
    for (int i = 0; i < 4; i++) wr(A_TX, 32'h20 + i);
    step(A_TX, 4'hF, 32'h55, 1'b0, 1'b1, 1'b0, '0);
    rd(A_ST);
    chk("txpp_status", RData, 32'h0004_0001);
    step(A_CT, 4'hF, 32'h2, 1'b0, 1'b1, 1'b1, 8'h66);
    rd(A_ST);
    chk("flush_concurrent", RData, 32'h0000_0001);

    // Asynchronous reset while the UART is draining a loaded TX FIFO.
    for (int i = 0; i < 5; i++) wr(A_TX, 32'h30 + i);
    rd(A_ST);
    chk("pre_reset_status", RData, 32'h0005_0001);
    mon_en = 0;
    RE = 1'b0; WE = '0; DataInReady = 1'b1;
    #2;
    Reset = 1'b1;
    #1;
    chk("async_in_valid", 32'(DataInValid), 32'h0);
    chk("async_rdata", RData, 32'h0);
    chk("async_out_ready", 32'(DataOutReady), 32'h1);
    m_tx.delete(); m_rx.delete(); exp_rd.delete(); exp_tx.delete();
    m_ovf = 0; m_unf = 0; last_rd = '0; rd_pending = 0;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    DataInReady = 1'b0;
    mon_en = 1;
    rd(A_ST);
    chk("post_reset_status", RData, 32'h0000_0001);

    // Randomized traffic across every register and the UART side.
    for (int n = 0; n < 3000; n++) begin
      int          sel;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  we;
      sel = $urandom_range(0, 5);
      wd  = $urandom;
      case (sel)
        0:       a = A_ST;
        1:       a = A_RX;
        2, 3:    a = A_TX;
        4:       a = A_CT;
        default: a = ($urandom_range(0, 1) != 0) ? BASE + 32'h10 : BASE + 32'h6;
      endcase
      if (a == A_CT && $urandom_range(0, 7) != 0) wd[1] = 1'b0;
      we = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      step(a, we, wd, $urandom_range(0, 1) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) != 0, 8'($urandom));
    end
    repeat (3) idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
